// File: rtl/ptos_tx_sched.sv
// Transmit scheduler for the parallel-to-serial shifter: round-robin word
// arbitration, shifter load strobe, bit counting and inter-frame gap.
module ptos_tx_sched #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned GAP   = 1,
    parameter logic        FILL  = 1'b1
) (
    input  logic                       Clock,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [WIDTH-1:0]           data0,
    input  logic [WIDTH-1:0]           data1,
    output logic                       ack0,
    output logic                       ack1,
    output logic                       load,
    output logic [WIDTH-1:0]           shData,
    output logic                       sIn,
    output logic                       tx_valid,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic                       frame_done,
    output logic                       grant,
    output logic                       busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            tx_valid_q, tx_valid_d;
    logic [CW-1:0]   bit_idx_q, bit_idx_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;

    logic            window_c;
    logic            sel_c;

    assign sIn        = FILL;
    assign tx_valid   = tx_valid_q;
    assign bit_idx    = bit_idx_q;
    assign frame_done = frame_done_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

    // Load window, round-robin winner and the combinational handshake toward sources
    always_comb begin
        window_c = 1'b0;
        case (state_q)
            ST_IDLE: window_c = 1'b1;
            ST_SEND: window_c = (cnt_q == '0) && (GAP == 0);
            ST_GAP:  window_c = (gcnt_q == '0);
            default: window_c = 1'b0;
        endcase
        sel_c  = (req0 && req1) ? ~last_q : req1;
        load   = window_c && en && (req0 || req1);
        ack0   = load && !sel_c;
        ack1   = load && sel_c;
        shData = load ? (sel_c ? data1 : data0) : '0;
    end

    // Next-state, counters and the registered status outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        grant_d = grant_q;
        last_d  = last_q;

        if (load) begin
            grant_d = sel_c;
            last_d  = sel_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SEND;
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
            ST_SEND: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (load) begin
                    cnt_d = CW'(WIDTH - 1);
                end else if (GAP != 0) begin
                    state_d = ST_GAP;
                    gcnt_d  = GW'(GAP - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gcnt_q != '0) begin
                    gcnt_d = gcnt_q - GW'(1);
                end else if (load) begin
                    state_d = ST_SEND;
                    cnt_d   = CW'(WIDTH - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status describes the cycle after the edge, so derive it from next state
        tx_valid_d   = (state_d == ST_SEND);
        bit_idx_d    = tx_valid_d ? cnt_d : '0;
        frame_done_d = tx_valid_d && (cnt_d == '0);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gcnt_q       <= '0;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            tx_valid_q   <= 1'b0;
            bit_idx_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gcnt_q       <= gcnt_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            tx_valid_q   <= tx_valid_d;
            bit_idx_q    <= bit_idx_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: doc/ptos_tx_sched.md
# ptos_tx_sched

Transmit scheduler for the 10-bit parallel-to-serial shifter. It arbitrates round-robin between two word sources and drives the shifter's `load`, `data` and `sIn` lines. It then counts the shifter through exactly WIDTH bit cycles, flagging valid serial bits and frame completion, and enforces a programmable inter-frame gap. It sits between the word producers and the shifter instance in the serial output path.

## Interface
- WIDTH, 10, frame length in bits; must match the shifter width.
- GAP, 1, idle cycles between consecutive frames (0 = back-to-back).
- FILL, 1'b1, constant value driven on `sIn`.

Ports:
- Clock  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  1  high permits new frames to start; a frame already in progress always completes.
- req0, req1  in  1  request from source 0/1; held high until the matching ack.
- data0, data1  in  WIDTH  word from source 0/1; stable while its req is high.
- ack0, ack1  out  1  one-cycle acceptance pulse, coincident with `load`.
- load  out  1  shifter load strobe.
- shData  out  WIDTH  word to the shifter; the granted source's word when `load`=1, else 0.
- sIn  out  1  tied to FILL.
- tx_valid  out  1  shifter serial output holds a frame bit this cycle.
- bit_idx  out  $clog2(WIDTH)  index of the bit currently on the shifter output (WIDTH-1 down to 0).
- frame_done  out  1  high during the last bit cycle of a frame.
- grant  out  1  owner of the frame currently shifting (0/1).
- busy  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: no frame.
  - SEND: bit counter `cnt` runs WIDTH-1 down to 0.
  - GAP: `gcnt` runs GAP-1 down to 0.
- Load window: IDLE; or SEND with `cnt`=0 and GAP=0; or GAP with `gcnt`=0.
- `load`, `ack*` and `shData` are combinational. `load`=1 iff in the load window, `en`=1, and (`req0`|`req1`).
- Arbitration winner `sel`:
  - Only one request high: that requester wins.
  - Both high: the requester not equal to `last` wins.
  - `last` resets to 1, so requester 0 wins the first contest.
- On the rising edge with `load`=1: `grant`←`sel`, `last`←`sel`, `cnt`←WIDTH-1, state←SEND.
- `ack0` = `load`&~`sel`; `ack1` = `load`&`sel`.
- SEND:
  - `tx_valid`=1, `bit_idx`=`cnt`; `cnt` decrements each edge.
  - At `cnt`=0, `frame_done`=1.
  - Next edge from `cnt`=0:
    - `load`=1 → SEND with `cnt`=WIDTH-1.
    - Else if GAP>0 → GAP with `gcnt`=GAP-1.
    - Else → IDLE.
- GAP:
  - `tx_valid`=0; `gcnt` decrements each edge.
  - At `gcnt`=0: `load` → SEND, else → IDLE.
- `en` low:
  - Blocks `load` only; SEND and GAP proceed normally.
  - A window missed due to `en` or no request ends in IDLE, which is always a load window.
- Reset (asynchronous, any state):
  - State IDLE, `cnt`=0, `gcnt`=0, `grant`=0, `last`=1.
  - Result: `tx_valid`, `frame_done`, `busy`, `bit_idx`=0. `load`/`ack*`/`shData` are 0 unless a request is already pending.
  - A partial frame is abandoned with no `frame_done` and no re-ack.

## Timing
- Load edge E: the shifter captures `shData`. Cycles E+1..E+WIDTH carry bits data[WIDTH-1]..data[0]; `tx_valid`=1 and `bit_idx`=WIDTH-1..0 in those cycles.
- `frame_done` is in cycle E+WIDTH.
- Continuous requests:
  - Frame start period is WIDTH+GAP cycles.
  - `tx_valid` is low for exactly GAP cycles between frames.
  - With GAP=0, `tx_valid` stays high continuously.
- Request-to-ack latency from IDLE is 0 cycles: `ack` is in the same cycle `req` is first seen high, if `en`=1.
- A requester must not drop `req` before `ack`. It may present a new word in the cycle after `ack`.
- `ack` is at most one per load.

## Test plan
- Single frame:
  - Stimulus: GAP=1; `req0`=1, data0=10'b1000010100 in IDLE.
  - Response: `ack0`/`load` the same cycle; `shData`=10'b1000010100; then 10 cycles with `tx_valid`=1 and `bit_idx` 9..0, serial 1,0,0,0,0,1,0,1,0,0; `frame_done` on the 10th; then 1 GAP cycle; then `busy`=0.
- Contention:
  - Stimulus: `req0` and `req1` both held high with new words after each ack.
  - Response: grants alternate 0,1,0,1; loads are 11 cycles apart (GAP=1).
- Back-to-back:
  - Stimulus: GAP=0, `req1` held high.
  - Response: `load` coincides with every `frame_done`; `tx_valid` is never low across 3 frames.
- Gate:
  - Stimulus: `en`=0 with `req0` high.
  - Response: no `load` and no `ack`.
  - Stimulus: `en` dropped mid-frame.
  - Response: the frame completes with `frame_done`; no further load occurs until `en`=1, then `load` in that same cycle.
- Reset mid-frame:
  - Stimulus: `rst` low at `bit_idx`=5.
  - Response: immediately `tx_valid`=`busy`=0, with no `frame_done`. After release with both requests high, requester 0 is granted first.
- Gap spacing:
  - Stimulus: GAP=3, `req0` held high.
  - Response: exactly 3 cycles with `tx_valid`=0 between frames; the next `load` is in the 3rd gap cycle.
